// File: rtl/seq_result_checker.sv
// Walks a memory region over a secondary read port and checks every word against a
// regenerated Fibonacci / arithmetic / constant sequence, keeping pass/fail counts and the first mismatch.
module seq_result_checker #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              dir,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    input  logic              stop_on_fail,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              first_fail_vld,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [DATA_W-1:0] first_fail_exp,
    output logic [DATA_W-1:0] first_fail_act,
    output logic              timeout_err
);
    localparam int unsigned       TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 2);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CMP, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               dir_q, dir_d, sof_q, sof_d;
    logic [CNT_W-1:0]   count_q, count_d, idx_q, idx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  exp_q, exp_d, nxt_q, nxt_d, data_q, data_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   pass_q, pass_d, fail_q, fail_d;
    logic               ffv_q, ffv_d, tmo_q, tmo_d;
    logic [ADDR_W-1:0]  ffa_q, ffa_d;
    logic [DATA_W-1:0]  ffe_q, ffe_d, ffact_q, ffact_d;
    logic               mismatch;

    assign mismatch        = (data_q != exp_q);
    assign rd_req          = (state_q == S_REQ);
    assign rd_addr         = rd_req ? addr_q : '0;
    assign busy            = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_CMP);
    assign done            = (state_q == S_DONE);
    assign pass_cnt        = pass_q;
    assign fail_cnt        = fail_q;
    assign first_fail_vld  = ffv_q;
    assign first_fail_addr = ffa_q;
    assign first_fail_exp  = ffe_q;
    assign first_fail_act  = ffact_q;
    assign timeout_err     = tmo_q;

    always_comb begin
        state_d = state_q;  mode_d  = mode_q;  dir_d   = dir_q;   sof_d   = sof_q;
        count_d = count_q;  idx_d   = idx_q;   addr_d  = addr_q;  exp_d   = exp_q;
        nxt_d   = nxt_q;    data_d  = data_q;  timer_d = timer_q; pass_d  = pass_q;
        fail_d  = fail_q;   ffv_d   = ffv_q;   ffa_d   = ffa_q;   ffe_d   = ffe_q;
        ffact_d = ffact_q;  tmo_d   = tmo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d  = mode;       dir_d   = dir;     sof_d   = stop_on_fail;
                    count_d = count;      addr_d  = base_addr;
                    exp_d   = seed0;      nxt_d   = seed1;   idx_d   = '0;
                    pass_d  = '0;         fail_d  = '0;      ffv_d   = 1'b0;
                    ffa_d   = '0;         ffe_d   = '0;      ffact_d = '0;
                    tmo_d   = 1'b0;
                    state_d = (count == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // timeout_err appears TIMEOUT cycles after the rd_req cycle
                if (rd_valid) begin
                    data_d  = rd_data;
                    state_d = S_CMP;
                end else if (timer_q == TMR_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_CMP: begin
                if (!mismatch) begin
                    if (pass_q != CNT_MAX) pass_d = pass_q + CNT_W'(1);
                end else begin
                    if (fail_q != CNT_MAX) fail_d = fail_q + CNT_W'(1);
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffa_d   = addr_q;
                        ffe_d   = exp_q;
                        ffact_d = data_q;
                    end
                end
                // nxt_q holds e(n+1) for Fibonacci and the step for arithmetic
                case (mode_q)
                    2'b01:   exp_d = exp_q + nxt_q;
                    2'b10:   exp_d = exp_q;
                    default: begin
                        exp_d = nxt_q;
                        nxt_d = exp_q + nxt_q;
                    end
                endcase
                addr_d = dir_q ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
                idx_d  = idx_q + CNT_W'(1);
                if ((idx_d == count_q) || (mismatch && sof_q)) state_d = S_DONE;
                else                                          state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE; mode_q  <= '0; dir_q   <= 1'b0; sof_q   <= 1'b0;
            count_q <= '0;     idx_q   <= '0; addr_q  <= '0;   exp_q   <= '0;
            nxt_q   <= '0;     data_q  <= '0; timer_q <= '0;   pass_q  <= '0;
            fail_q  <= '0;     ffv_q   <= 1'b0; ffa_q <= '0;   ffe_q   <= '0;
            ffact_q <= '0;     tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d; mode_q  <= mode_d;  dir_q   <= dir_d;   sof_q   <= sof_d;
            count_q <= count_d; idx_q   <= idx_d;   addr_q  <= addr_d;  exp_q   <= exp_d;
            nxt_q   <= nxt_d;   data_q  <= data_d;  timer_q <= timer_d; pass_q  <= pass_d;
            fail_q  <= fail_d;  ffv_q   <= ffv_d;   ffa_q   <= ffa_d;   ffe_q   <= ffe_d;
            ffact_q <= ffact_d; tmo_q   <= tmo_d;
        end
    end
endmodule
